// File: rtl/fft_trigger_scanner.sv
// Scans a bin band of the trigger FFT output RAM for the largest |real| value
// and pulses trigger after a run of consecutive frames whose peak beats the threshold.
module fft_trigger_scanner #(
  parameter int         BIN_LO        = 2,
  parameter int         BIN_HI        = 20,
  parameter logic [9:0] THRESHOLD     = 10'd100,
  parameter int         HITS_REQUIRED = 3
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              scan_enable,
  input  logic              frame_done,
  input  logic              ram_ready,
  input  logic signed [9:0] ram_data,
  output logic [5:0]        ram_addr,
  output logic              scan_busy,
  output logic              trigger,
  output logic [5:0]        peak_bin,
  output logic [9:0]        peak_mag
);

  localparam logic [5:0] LO   = 6'(BIN_LO);
  localparam logic [5:0] HI   = 6'(BIN_HI);
  localparam logic [3:0] HITS = 4'(HITS_REQUIRED);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    READ,
    DRAIN,
    DECIDE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        rd_valid;
  logic [5:0]  rd_bin;
  logic [9:0]  run_mag;
  logic [5:0]  run_bin;
  logic [3:0]  hit_count;
  logic [9:0]  mag;
  logic        hit;
  logic        last;

  // -512 negates to itself in 10 bits, which reads back as unsigned 512
  assign mag       = ram_data[9] ? $unsigned(-ram_data)
                                 : $unsigned(ram_data);
  assign hit       = run_mag > THRESHOLD;
  assign last      = ram_addr == HI;
  assign scan_busy = state != IDLE;

  always_ff @(posedge clk) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (frame_done && scan_enable) state_n = WAIT_RDY;
      WAIT_RDY: if (ram_ready) state_n = READ;
      READ: begin
        if (!ram_ready) state_n = IDLE;
        else if (last)  state_n = DRAIN;
      end
      DRAIN:    state_n = ram_ready ? DECIDE : IDLE;
      DECIDE:   state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      ram_addr  <= '0;
      rd_valid  <= 1'b0;
      rd_bin    <= '0;
      run_mag   <= '0;
      run_bin   <= '0;
      hit_count <= '0;
      trigger   <= 1'b0;
      peak_bin  <= '0;
      peak_mag  <= '0;
    end else begin
      trigger  <= 1'b0;
      rd_valid <= (state == READ) && ram_ready;
      rd_bin   <= ram_addr;

      if (state == WAIT_RDY && ram_ready) begin
        ram_addr <= LO;
        run_mag  <= '0;
        run_bin  <= LO;
      end else if (state == READ && !last) begin
        ram_addr <= ram_addr + 6'd1;
      end

      // strict compare keeps the lowest bin on ties
      if (rd_valid && (state == READ || state == DRAIN)
          && mag > run_mag) begin
        run_mag <= mag;
        run_bin <= rd_bin;
      end

      if (state == DECIDE) begin
        peak_bin <= run_bin;
        peak_mag <= run_mag;
        if (scan_enable && hit) begin
          if (hit_count + 4'd1 == HITS) begin
            trigger   <= 1'b1;
            hit_count <= '0;
          end else begin
            hit_count <= hit_count + 4'd1;
          end
        end else begin
          hit_count <= '0;
        end
      end

      if (!scan_enable) hit_count <= '0;
    end
  end

endmodule

// File: tb/tb_fft_trigger_scanner.sv
// Directed bench for fft_trigger_scanner: default build plus a
// single-hit build sharing one RAM model.
module tb_fft_trigger_scanner;

  logic              clk = 1'b0;
  logic              reset_b = 1'b0;
  logic              scan_enable = 1'b1;
  logic              frame_done = 1'b0;
  logic              ram_ready = 1'b1;
  logic signed [9:0] ram_data = '0;
  logic [5:0]        ram_addr, ram_addr1;
  logic              scan_busy, scan_busy1;
  logic              trigger, trigger1;
  logic [5:0]        peak_bin, peak_bin1;
  logic [9:0]        peak_mag, peak_mag1;

  logic signed [9:0] mem [64];
  logic              busy_log [64];
  logic [5:0]        addr_log [64];
  int trig_k, trig_n, trig1_k, trig1_n;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) ram_data <= mem[ram_addr];

  fft_trigger_scanner dut (
    .clk(clk), .reset_b(reset_b), .scan_enable(scan_enable),
    .frame_done(frame_done), .ram_ready(ram_ready),
    .ram_data(ram_data), .ram_addr(ram_addr),
    .scan_busy(scan_busy), .trigger(trigger),
    .peak_bin(peak_bin), .peak_mag(peak_mag)
  );

  fft_trigger_scanner #(.HITS_REQUIRED(1)) dut1 (
    .clk(clk), .reset_b(reset_b), .scan_enable(scan_enable),
    .frame_done(frame_done), .ram_ready(ram_ready),
    .ram_data(ram_data), .ram_addr(ram_addr1),
    .scan_busy(scan_busy1), .trigger(trigger1),
    .peak_bin(peak_bin1), .peak_mag(peak_mag1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_bg;
    for (int i = 0; i < 64; i++)
      mem[i] = (i % 2 == 1) ? -10'sd50 : 10'sd50;
  endtask

  // k counts cycles after the frame_done cycle
  task automatic scan_frame(input int drop_k, input int refd_k,
                            input int enlow_k);
    trig_k = 0; trig_n = 0; trig1_k = 0; trig1_n = 0;
    frame_done = 1'b1;
    tick;
    frame_done = 1'b0;
    for (int k = 1; k < 64; k++) begin
      busy_log[k] = scan_busy;
      addr_log[k] = ram_addr;
      if (trigger) begin
        trig_n++;
        if (trig_k == 0) trig_k = k;
      end
      if (trigger1) begin
        trig1_n++;
        if (trig1_k == 0) trig1_k = k;
      end
      frame_done = (k == refd_k);
      if (k == drop_k) ram_ready = 1'b0;
      if (k == drop_k + 3) ram_ready = 1'b1;
      if (k == enlow_k) scan_enable = 1'b0;
      tick;
    end
    frame_done = 1'b0;
    ram_ready = 1'b1;
    scan_enable = 1'b1;
  endtask

  task automatic test_reset;
    reset_b = 1'b0;
    repeat (2) tick;
    checks++; if (ram_addr !== 6'd0) $display("FAIL rst_addr: got %0d need 0", ram_addr); else passes++;
    checks++; if (scan_busy !== 1'b0) $display("FAIL rst_busy: got %0b need 0", scan_busy); else passes++;
    checks++; if (trigger !== 1'b0) $display("FAIL rst_trig: got %0b need 0", trigger); else passes++;
    checks++; if (peak_bin !== 6'd0) $display("FAIL rst_bin: got %0d need 0", peak_bin); else passes++;
    checks++; if (peak_mag !== 10'd0) $display("FAIL rst_mag: got %0d need 0", peak_mag); else passes++;
    reset_b = 1'b1;
    tick;
  endtask

  task automatic test_single_peak;
    set_bg;
    mem[7] = -10'sd300;
    scan_frame(0, 0, 0);
    checks++; if (trig1_k !== 23) $display("FAIL sp_latency: got %0d need 23", trig1_k); else passes++;
    checks++; if (trig1_n !== 1) $display("FAIL sp_pulses: got %0d need 1", trig1_n); else passes++;
    checks++; if (peak_bin1 !== 6'd7) $display("FAIL sp_bin: got %0d need 7", peak_bin1); else passes++;
    checks++; if (peak_mag1 !== 10'd300) $display("FAIL sp_mag: got %0d need 300", peak_mag1); else passes++;
    checks++; if (addr_log[2] !== 6'd2) $display("FAIL sp_addr_first: got %0d need 2", addr_log[2]); else passes++;
    checks++; if (addr_log[20] !== 6'd20) $display("FAIL sp_addr_last: got %0d need 20", addr_log[20]); else passes++;
    checks++; if (addr_log[21] !== 6'd20) $display("FAIL sp_addr_hold: got %0d need 20", addr_log[21]); else passes++;
    checks++; if (busy_log[1] !== 1'b1) $display("FAIL sp_busy_start: got %0b need 1", busy_log[1]); else passes++;
    checks++; if (busy_log[22] !== 1'b1) $display("FAIL sp_busy_end: got %0b need 1", busy_log[22]); else passes++;
    checks++; if (busy_log[23] !== 1'b0) $display("FAIL sp_busy_idle: got %0b need 0", busy_log[23]); else passes++;
    checks++; if (trig_n !== 0) $display("FAIL sp_default_trig: got %0d need 0", trig_n); else passes++;
  endtask

  task automatic test_consecutive;
    int total;
    int which;
    logic [9:0] miss_mag;
    set_bg;
    scan_frame(0, 0, 0);
    checks++; if (peak_mag !== 10'd50) $display("FAIL miss_mag: got %0d need 50", peak_mag); else passes++;
    checks++; if (peak_bin !== 6'd2) $display("FAIL miss_bin: got %0d need 2", peak_bin); else passes++;
    mem[10] = 10'sd150;
    scan_frame(0, 0, 0);
    checks++; if (trig_n !== 0) $display("FAIL hit1_trig: got %0d need 0", trig_n); else passes++;
    scan_frame(0, 0, 0);
    checks++; if (trig_n !== 0) $display("FAIL hit2_trig: got %0d need 0", trig_n); else passes++;
    scan_frame(0, 0, 0);
    checks++; if (trig_k !== 23) $display("FAIL hit3_trig: got %0d need 23", trig_k); else passes++;
    checks++; if (peak_bin !== 6'd10) $display("FAIL hit3_bin: got %0d need 10", peak_bin); else passes++;
    total = 0; which = 0; miss_mag = '0;
    for (int f = 1; f <= 6; f++) begin
      mem[10] = (f == 3) ? 10'sd100 : 10'sd150;
      scan_frame(0, 0, 0);
      if (f == 3) miss_mag = peak_mag;
      if (trig_n > 0) begin
        total += trig_n;
        which = f;
      end
    end
    checks++; if (miss_mag !== 10'd100) $display("FAIL seq_miss_mag: got %0d need 100", miss_mag); else passes++;
    checks++; if (total !== 1) $display("FAIL seq_count: got %0d need 1", total); else passes++;
    checks++; if (which !== 6) $display("FAIL seq_frame: got %0d need 6", which); else passes++;
  endtask

  task automatic test_ties_edges;
    set_bg;
    mem[2] = 10'sd400;
    mem[20] = 10'sd400;
    scan_frame(0, 0, 0);
    checks++; if (peak_bin !== 6'd2) $display("FAIL tie_bin: got %0d need 2", peak_bin); else passes++;
    checks++; if (peak_mag !== 10'd400) $display("FAIL tie_mag: got %0d need 400", peak_mag); else passes++;
    set_bg;
    mem[1] = 10'sd511;
    mem[21] = 10'sd511;
    scan_frame(0, 0, 0);
    checks++; if (peak_mag !== 10'd50) $display("FAIL edge_mag: got %0d need 50", peak_mag); else passes++;
    set_bg;
    mem[5] = -10'sd512;
    scan_frame(0, 0, 0);
    checks++; if (peak_mag !== 10'd512) $display("FAIL neg512_mag: got %0d need 512", peak_mag); else passes++;
    checks++; if (peak_bin !== 6'd5) $display("FAIL neg512_bin: got %0d need 5", peak_bin); else passes++;
  endtask

  task automatic test_abort;
    set_bg;
    scan_frame(0, 0, 0);
    mem[10] = 10'sd150;
    scan_frame(0, 0, 0);
    scan_frame(0, 0, 0);
    mem[4] = 10'sd480;
    scan_frame(7, 0, 0);
    checks++; if (busy_log[8] !== 1'b0) $display("FAIL abort_busy: got %0b need 0", busy_log[8]); else passes++;
    checks++; if (trig_n + trig1_n !== 0) $display("FAIL abort_trig: got %0d need 0", trig_n + trig1_n); else passes++;
    checks++; if (peak_mag !== 10'd150) $display("FAIL abort_mag: got %0d need 150", peak_mag); else passes++;
    checks++; if (peak_bin !== 6'd10) $display("FAIL abort_bin: got %0d need 10", peak_bin); else passes++;
    scan_frame(0, 0, 0);
    checks++; if (trig_k !== 23) $display("FAIL post_abort_trig: got %0d need 23", trig_k); else passes++;
    checks++; if (peak_mag !== 10'd480) $display("FAIL post_abort_mag: got %0d need 480", peak_mag); else passes++;
    checks++; if (peak_bin !== 6'd4) $display("FAIL post_abort_bin: got %0d need 4", peak_bin); else passes++;
  endtask

  task automatic test_back_to_back;
    set_bg;
    mem[10] = 10'sd150;
    scan_frame(0, 10, 0);
    checks++; if (trig1_n !== 1) $display("FAIL b2b_pulses: got %0d need 1", trig1_n); else passes++;
    checks++; if (busy_log[30] !== 1'b0) $display("FAIL b2b_busy: got %0b need 0", busy_log[30]); else passes++;
  endtask

  task automatic test_enable_gating;
    set_bg;
    scan_frame(0, 0, 0);
    mem[10] = 10'sd150;
    scan_frame(0, 0, 0);
    scan_frame(0, 0, 0);
    scan_enable = 1'b0;
    tick;
    scan_enable = 1'b1;
    tick;
    scan_frame(0, 0, 0);
    checks++; if (trig_n !== 0) $display("FAIL gate_trig: got %0d need 0", trig_n); else passes++;
    scan_frame(0, 0, 0);
    checks++; if (trig_n !== 0) $display("FAIL gate_hit2: got %0d need 0", trig_n); else passes++;
    scan_frame(0, 0, 0);
    checks++; if (trig_k !== 23) $display("FAIL gate_hit3: got %0d need 23", trig_k); else passes++;
    mem[10] = 10'sd200;
    scan_frame(0, 0, 5);
    checks++; if (trig1_n !== 0) $display("FAIL inscan_trig: got %0d need 0", trig1_n); else passes++;
    checks++; if (peak_mag1 !== 10'd200) $display("FAIL inscan_mag: got %0d need 200", peak_mag1); else passes++;
  endtask

  task automatic test_reset_mid;
    int n;
    set_bg;
    mem[10] = 10'sd150;
    frame_done = 1'b1;
    tick;
    frame_done = 1'b0;
    repeat (7) tick;
    reset_b = 1'b0;
    tick;
    checks++; if (ram_addr !== 6'd0) $display("FAIL mid_addr: got %0d need 0", ram_addr); else passes++;
    checks++; if (scan_busy !== 1'b0) $display("FAIL mid_busy: got %0b need 0", scan_busy); else passes++;
    checks++; if (peak_mag1 !== 10'd0) $display("FAIL mid_mag: got %0d need 0", peak_mag1); else passes++;
    checks++; if (peak_bin !== 6'd0) $display("FAIL mid_bin: got %0d need 0", peak_bin); else passes++;
    reset_b = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (trigger || trigger1 || scan_busy) n++;
      tick;
    end
    checks++; if (n !== 0) $display("FAIL mid_quiet: got %0d need 0", n); else passes++;
  endtask

  initial begin
    set_bg;
    test_reset;
    test_single_peak;
    test_consecutive;
    test_ties_edges;
    test_abort;
    test_back_to_back;
    test_enable_gating;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
